// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

   // Direction encoding for the 'up' input
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Legal parameter ranges
   localparam int WIDTH_MIN    = 1;
   localparam int WIDTH_MAX    = 32;
   localparam int PRESCALE_MIN = 1;
   localparam int PRESCALE_MAX = 65535;

   // Bits needed to hold the values 0..value-1 (never less than 1)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mod_n_updown_counter_step_prescaler.sv
// Divides enabled cycles by PRESCALE: tick is high on every PRESCALE-th enabled cycle.
module step_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pc_reg;
   logic [PW-1:0] pc_next;

   // Tick on the last slot of the period, only while enabled
   assign tick = en && (pc_reg == LAST);

   // Next prescaler count: clear wins, en=0 freezes, wrap after the last slot
   always_comb begin
      pc_next = pc_reg;
      if (clr) begin
         pc_next = '0;
      end else if (en) begin
         pc_next = tick ? '0 : pc_reg + 1'b1;
      end
   end

   // Prescaler state register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         pc_reg <= '0;
      end else begin
         pc_reg <= pc_next;
      end
   end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Runtime-programmable modulo (max_val+1) up/down counter with load, enable,
// optional step prescaler and one-shot stop at the terminal value.
module mod_n_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic             up,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   // Reject out-of-range parameters when the design is elaborated
   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
          PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_param
         $error("mod_n_updown_counter: WIDTH or PRESCALE out of range");
      end
   endgenerate

   logic [WIDTH-1:0] count_reg, count_next;
   logic             wrap_reg, wrap_next;
   logic             done_reg, done_next;
   logic             presc_tick;
   logic             step;
   logic             terminal;

   // Prescaler only exists when steps are divided; otherwise every enabled cycle steps
   generate
      if (PRESCALE > 1) begin : g_presc
         step_prescaler #(
            .PRESCALE (PRESCALE)
         ) u_presc (
            .CLK  (CLK),
            .RST  (RST),
            .clr  (load),
            .en   (en),
            .tick (presc_tick)
         );
      end else begin : g_no_presc
         assign presc_tick = 1'b1;
      end
   endgenerate

   assign step = en & presc_tick;

   // A step is terminal at the top going up, or at 0 / out of range going down
   assign terminal = (up == DIR_UP) ? (count_reg >= max_val)
                                    : ((count_reg == '0) || (count_reg > max_val));

   // Cascade output: purely from the current count, bound and direction
   assign tc = (up == DIR_UP) ? (count_reg == max_val) : (count_reg == '0);

   // Next-state: load beats step, step beats hold; done freezes stepping
   always_comb begin
      count_next = count_reg;
      wrap_next  = 1'b0;
      done_next  = done_reg;
      if (load) begin
         count_next = (load_val > max_val) ? max_val : load_val;
         done_next  = 1'b0;
      end else if (step && !done_reg) begin
         if (terminal) begin
            wrap_next = 1'b1;
            if (oneshot) begin
               done_next = 1'b1;
            end else begin
               count_next = (up == DIR_UP) ? '0 : max_val;
            end
         end else begin
            count_next = (up == DIR_UP) ? count_reg + 1'b1 : count_reg - 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         count_reg <= '0;
         wrap_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
         done_reg  <= done_next;
      end
   end

   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign done  = done_reg;

endmodule
